// File: rtl/gcm_ghash_formatter_if.sv
// Handshake and data bundle between a block source, the GHASH formatter and the
// GHASH core. The formatter sits on the slave side.
interface gcm_ghash_formatter_if;
   logic         start_i;
   logic [127:0] data_i;
   logic         kind_i;
   logic [4:0]   bytes_i;
   logic         last_i;
   logic         valid_i;
   logic         ready_o;
   logic [127:0] dout_o;
   logic         dout_valid_o;
   logic         dout_ready_i;
   logic         dout_last_o;
   logic         busy_o;
   logic         err_o;

   modport master (
      output start_i, data_i, kind_i, bytes_i, last_i, valid_i, dout_ready_i,
      input  ready_o, dout_o, dout_valid_o, dout_last_o, busy_o, err_o
   );

   modport slave (
      input  start_i, data_i, kind_i, bytes_i, last_i, valid_i, dout_ready_i,
      output ready_o, dout_o, dout_valid_o, dout_last_o, busy_o, err_o
   );
endinterface

// File: rtl/gcm_ghash_formatter.sv
// Formats AAD and ciphertext blocks for GHASH: zero-pads partial blocks, counts
// AAD/ciphertext bits and closes each message with the {aad_bits, ct_bits} block.
module gcm_ghash_formatter (
   input  logic                         clk,
   input  logic                         rst_n,
   gcm_ghash_formatter_if.slave         bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_LEN  = 2'd2
   } state_t;

   // Keep the first n bytes (byte 0 in the top octet) and zero the rest.
   function automatic logic [127:0] mask_bytes(input logic [127:0] d, input logic [4:0] n);
      logic [127:0] r;
      r = 128'd0;
      for (int i = 0; i < 16; i++) begin
         if (5'(i) < n) begin
            r[127 - 8*i -: 8] = d[127 - 8*i -: 8];
         end else begin
            r[127 - 8*i -: 8] = 8'h00;
         end
      end
      return r;
   endfunction

   state_t         state_q, state_d;
   logic [127:0]   dout_q, dout_d;
   logic           dout_valid_q, dout_valid_d;
   logic           dout_last_q, dout_last_d;
   logic [63:0]    aad_bits_q, aad_bits_d;
   logic [63:0]    ct_bits_q, ct_bits_d;
   logic           phase_q, phase_d;
   logic           err_q, err_d;

   logic           ready_s;
   logic           out_free_s;
   logic           accept_s;
   logic [4:0]     bytes_sat_s;
   logic [63:0]    bits_inc_s;

   // Next-state, datapath and handshake decode.
   always_comb begin
      state_d      = state_q;
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;
      dout_last_d  = dout_last_q;
      aad_bits_d   = aad_bits_q;
      ct_bits_d    = ct_bits_q;
      phase_d      = phase_q;
      err_d        = err_q;
      ready_s      = 1'b0;

      out_free_s  = !dout_valid_q || bus.dout_ready_i;
      bytes_sat_s = (bus.bytes_i > 5'd16) ? 5'd16 : bus.bytes_i;
      bits_inc_s  = {56'd0, bytes_sat_s, 3'd0};

      // A completed transfer empties the register unless a load below refills it.
      if (dout_valid_q && bus.dout_ready_i) begin
         dout_valid_d = 1'b0;
         dout_last_d  = 1'b0;
      end else begin
         dout_valid_d = dout_valid_q;
         dout_last_d  = dout_last_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (bus.start_i) begin
               state_d    = ST_DATA;
               aad_bits_d = 64'd0;
               ct_bits_d  = 64'd0;
               phase_d    = 1'b0;
               err_d      = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DATA: begin
            ready_s = out_free_s;
            if (bus.valid_i && ready_s) begin
               // AAD after ciphertext has started is an ordering error and is dropped.
               if (!bus.kind_i && phase_q) begin
                  err_d = 1'b1;
               end else if (bytes_sat_s != 5'd0) begin
                  dout_d       = mask_bytes(bus.data_i, bytes_sat_s);
                  dout_valid_d = 1'b1;
                  dout_last_d  = 1'b0;
                  if (bus.kind_i) begin
                     ct_bits_d = ct_bits_q + bits_inc_s;
                  end else begin
                     aad_bits_d = aad_bits_q + bits_inc_s;
                  end
               end else begin
                  err_d = err_q;
               end
               if (bus.kind_i) begin
                  phase_d = 1'b1;
               end else begin
                  phase_d = phase_q;
               end
               if (bus.last_i) begin
                  state_d = ST_LEN;
               end else begin
                  state_d = ST_DATA;
               end
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_LEN: begin
            if (out_free_s) begin
               dout_d       = {aad_bits_q, ct_bits_q};
               dout_valid_d = 1'b1;
               dout_last_d  = 1'b1;
               state_d      = ST_IDLE;
            end else begin
               state_d = ST_LEN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign accept_s = bus.valid_i && ready_s;

   // State and output register with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         dout_q       <= 128'd0;
         dout_valid_q <= 1'b0;
         dout_last_q  <= 1'b0;
         aad_bits_q   <= 64'd0;
         ct_bits_q    <= 64'd0;
         phase_q      <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         dout_last_q  <= dout_last_d;
         aad_bits_q   <= aad_bits_d;
         ct_bits_q    <= ct_bits_d;
         phase_q      <= phase_d;
         err_q        <= err_d;
      end
   end

   assign bus.ready_o      = ready_s;
   assign bus.dout_o       = dout_q;
   assign bus.dout_valid_o = dout_valid_q;
   assign bus.dout_last_o  = dout_last_q;
   assign bus.busy_o       = (state_q != ST_IDLE) || dout_valid_q;
   assign bus.err_o        = err_q;

   logic unused_s;
   assign unused_s = accept_s;

endmodule

// File: tb/tb_gcm_ghash_formatter.sv
// Directed bench for gcm_ghash_formatter: per-cycle vector table plus hand-written
// backpressure and mid-message reset sequences.
module tb_gcm_ghash_formatter;

   logic clk;
   logic rst_n;
   gcm_ghash_formatter_if bus();

   gcm_ghash_formatter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         st;
      logic         vl;
      logic         kd;
      logic [4:0]   nb;
      logic         ls;
      logic         dr;
      logic [127:0] data;
      logic         e_ready;
      logic         e_dv;
      logic         e_dl;
      logic         e_err;
      logic         e_busy;
      logic [127:0] e_dout;
   } vec_t;

   vec_t vq[$];
   int   n_tests;
   int   n_fail;

   localparam logic [127:0] D_INC = 128'h000102030405060708090A0B0C0D0E0F;
   localparam logic [127:0] D_FF  = {128{1'b1}};
   localparam logic [127:0] D_P5  = 128'hFFFFFFFFFF0000000000000000000000;
   localparam logic [127:0] D_P8  = 128'h00010203040506070000000000000000;
   localparam logic [127:0] D_A5  = {16{8'hA5}};
   localparam logic [127:0] D_5A  = {16{8'h5A}};
   localparam logic [127:0] D_S   = 128'h112233445566778899AABBCCDDEEFF00;
   localparam logic [127:0] Z     = 128'd0;

   function automatic vec_t mkv(input logic st, input logic vl, input logic kd,
                                input logic [4:0] nb, input logic ls, input logic dr,
                                input logic [127:0] data, input logic er, input logic edv,
                                input logic edl, input logic eerr, input logic ebusy,
                                input logic [127:0] edo);
      vec_t v;
      v.st = st; v.vl = vl; v.kd = kd; v.nb = nb; v.ls = ls; v.dr = dr; v.data = data;
      v.e_ready = er; v.e_dv = edv; v.e_dl = edl; v.e_err = eerr; v.e_busy = ebusy;
      v.e_dout = edo;
      return v;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic st, input logic vl, input logic kd, input logic [4:0] nb,
                        input logic ls, input logic dr, input logic [127:0] data);
      bus.start_i      = st;
      bus.valid_i      = vl;
      bus.kind_i       = kd;
      bus.bytes_i      = nb;
      bus.last_i       = ls;
      bus.dout_ready_i = dr;
      bus.data_i       = data;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, Z);

      // Full message: AAD 0x00..0x0F then all-FF ciphertext.
      vq.push_back(mkv(1'b1,1'b0,1'b0,5'd0, 1'b0,1'b1,Z,    1'b0,1'b0,1'b0,1'b0,1'b1,Z));
      vq.push_back(mkv(1'b0,1'b1,1'b0,5'd16,1'b0,1'b1,D_INC,1'b1,1'b1,1'b0,1'b0,1'b1,D_INC));
      vq.push_back(mkv(1'b0,1'b1,1'b1,5'd16,1'b1,1'b1,D_FF, 1'b1,1'b1,1'b0,1'b0,1'b1,D_FF));
      vq.push_back(mkv(1'b0,1'b0,1'b0,5'd0, 1'b0,1'b1,Z,    1'b0,1'b1,1'b1,1'b0,1'b1,{64'd128,64'd128}));
      vq.push_back(mkv(1'b0,1'b0,1'b0,5'd0, 1'b0,1'b1,Z,    1'b0,1'b0,1'b0,1'b0,1'b0,{64'd128,64'd128}));
      // Empty message.
      vq.push_back(mkv(1'b1,1'b0,1'b0,5'd0, 1'b0,1'b1,Z,    1'b0,1'b0,1'b0,1'b0,1'b1,{64'd128,64'd128}));
      vq.push_back(mkv(1'b0,1'b1,1'b0,5'd0, 1'b1,1'b1,D_FF, 1'b1,1'b0,1'b0,1'b0,1'b1,{64'd128,64'd128}));
      vq.push_back(mkv(1'b0,1'b0,1'b0,5'd0, 1'b0,1'b1,Z,    1'b0,1'b1,1'b1,1'b0,1'b1,Z));
      vq.push_back(mkv(1'b0,1'b0,1'b0,5'd0, 1'b0,1'b1,Z,    1'b0,1'b0,1'b0,1'b0,1'b0,Z));
      // Partial ciphertext, 5 bytes.
      vq.push_back(mkv(1'b1,1'b0,1'b0,5'd0, 1'b0,1'b1,Z,    1'b0,1'b0,1'b0,1'b0,1'b1,Z));
      vq.push_back(mkv(1'b0,1'b1,1'b1,5'd5, 1'b1,1'b1,D_FF, 1'b1,1'b1,1'b0,1'b0,1'b1,D_P5));
      vq.push_back(mkv(1'b0,1'b0,1'b0,5'd0, 1'b0,1'b1,Z,    1'b0,1'b1,1'b1,1'b0,1'b1,{64'd0,64'd40}));
      vq.push_back(mkv(1'b0,1'b0,1'b0,5'd0, 1'b0,1'b1,Z,    1'b0,1'b0,1'b0,1'b0,1'b0,{64'd0,64'd40}));
      // Ordering error: AAD after ciphertext is dropped.
      vq.push_back(mkv(1'b1,1'b0,1'b0,5'd0, 1'b0,1'b1,Z,    1'b0,1'b0,1'b0,1'b0,1'b1,{64'd0,64'd40}));
      vq.push_back(mkv(1'b0,1'b1,1'b1,5'd16,1'b0,1'b1,D_A5, 1'b1,1'b1,1'b0,1'b0,1'b1,D_A5));
      vq.push_back(mkv(1'b0,1'b1,1'b0,5'd16,1'b1,1'b1,D_5A, 1'b1,1'b0,1'b0,1'b1,1'b1,D_A5));
      vq.push_back(mkv(1'b0,1'b0,1'b0,5'd0, 1'b0,1'b1,Z,    1'b0,1'b1,1'b1,1'b1,1'b1,{64'd0,64'd128}));
      vq.push_back(mkv(1'b0,1'b0,1'b0,5'd0, 1'b0,1'b1,Z,    1'b0,1'b0,1'b0,1'b1,1'b0,{64'd0,64'd128}));
      // New start clears err; bytes_i=20 saturates to a full block.
      vq.push_back(mkv(1'b1,1'b0,1'b0,5'd0, 1'b0,1'b1,Z,    1'b0,1'b0,1'b0,1'b0,1'b1,{64'd0,64'd128}));
      vq.push_back(mkv(1'b0,1'b1,1'b0,5'd20,1'b1,1'b1,D_S,  1'b1,1'b1,1'b0,1'b0,1'b1,D_S));
      vq.push_back(mkv(1'b0,1'b0,1'b0,5'd0, 1'b0,1'b1,Z,    1'b0,1'b1,1'b1,1'b0,1'b1,{64'd128,64'd0}));
      vq.push_back(mkv(1'b0,1'b0,1'b0,5'd0, 1'b0,1'b1,Z,    1'b0,1'b0,1'b0,1'b0,1'b0,{64'd128,64'd0}));
      // valid_i in IDLE without start is ignored.
      vq.push_back(mkv(1'b0,1'b1,1'b1,5'd16,1'b1,1'b1,D_FF, 1'b0,1'b0,1'b0,1'b0,1'b0,{64'd128,64'd0}));

      repeat (2) @(posedge clk);
      #1;
      check("rst_dout",  bus.dout_o, Z);
      check("rst_dv",    128'(bus.dout_valid_o), 128'd0);
      check("rst_busy",  128'(bus.busy_o), 128'd0);
      check("rst_ready", 128'(bus.ready_o), 128'd0);
      check("rst_err",   128'(bus.err_o), 128'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         drive(vq[i].st, vq[i].vl, vq[i].kd, vq[i].nb, vq[i].ls, vq[i].dr, vq[i].data);
         #1;
         check($sformatf("v%0d_ready", i), 128'(bus.ready_o), 128'(vq[i].e_ready));
         @(posedge clk);
         #1;
         check($sformatf("v%0d_dv", i),   128'(bus.dout_valid_o), 128'(vq[i].e_dv));
         check($sformatf("v%0d_dl", i),   128'(bus.dout_last_o), 128'(vq[i].e_dl));
         check($sformatf("v%0d_err", i),  128'(bus.err_o), 128'(vq[i].e_err));
         check($sformatf("v%0d_busy", i), 128'(bus.busy_o), 128'(vq[i].e_busy));
         check($sformatf("v%0d_dout", i), bus.dout_o, vq[i].e_dout);
      end

      // Backpressure: block A pending, B waits three stalled cycles then follows at once.
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, Z);
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, D_INC);
      #1;
      check("bp_ready_a", 128'(bus.ready_o), 128'd1);
      @(posedge clk);
      #1;
      check("bp_dout_a", bus.dout_o, D_P8);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         drive(1'b0, 1'b1, 1'b1, 5'd16, 1'b1, 1'b0, D_FF);
         #1;
         check($sformatf("bp_stall%0d_ready", k), 128'(bus.ready_o), 128'd0);
         @(posedge clk);
         #1;
         check($sformatf("bp_stall%0d_dout", k), bus.dout_o, D_P8);
         check($sformatf("bp_stall%0d_dv", k), 128'(bus.dout_valid_o), 128'd1);
      end
      @(negedge clk);
      bus.dout_ready_i = 1'b1;
      #1;
      check("bp_ready_b", 128'(bus.ready_o), 128'd1);
      @(posedge clk);
      #1;
      check("bp_dout_b", bus.dout_o, D_FF);
      check("bp_dv_b", 128'(bus.dout_valid_o), 128'd1);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, Z);
      @(posedge clk);
      #1;
      check("bp_len", bus.dout_o, {64'd64, 64'd128});
      check("bp_len_last", 128'(bus.dout_last_o), 128'd1);

      // Reset with a block held in the output register.
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, Z);
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b1, 5'd16, 1'b0, 1'b0, D_A5);
      @(posedge clk);
      #1;
      check("mr_dv_before", 128'(bus.dout_valid_o), 128'd1);
      @(negedge clk);
      bus.valid_i = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("mr_dout",  bus.dout_o, Z);
      check("mr_dv",    128'(bus.dout_valid_o), 128'd0);
      check("mr_dl",    128'(bus.dout_last_o), 128'd0);
      check("mr_err",   128'(bus.err_o), 128'd0);
      check("mr_busy",  128'(bus.busy_o), 128'd0);
      check("mr_ready", 128'(bus.ready_o), 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 1'b1, 1'b1, 5'd16, 1'b1, 1'b1, D_FF);
      #1;
      check("mr_ready_after", 128'(bus.ready_o), 128'd0);
      @(posedge clk);
      #1;
      check("mr_dv_after", 128'(bus.dout_valid_o), 128'd0);
      check("mr_busy_after", 128'(bus.busy_o), 128'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
